endian_byte_unpacker: RTL

//  Versat functional unit that serialises DATA_W-bit words into a byte stream, one byte/cycle.

---
 rtl/endian_byte_unpacker.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/endian_byte_unpacker.sv
// -----------------------------------------------------------------------------
// endian_byte_unpacker
//   Serialises DATA_W-bit words into a byte stream, one byte per cycle.
//   Byte order is chosen per word (0 = LSB first, 1 = MSB first) and latched
//   when the word is accepted. Holds a single word; the next word is accepted
//   on the same edge the last byte leaves, so streaming runs without bubbles.
//
// Ports
//   clk          clock, all state on rising edge
//   rst          asynchronous active-low reset
//   run          1-cycle start pulse: arms the unit, drops held word, clears counter
//   enabled      byte order for the next accepted word (0 = LSB first, 1 = MSB first)
//   in0          input word
//   in0_valid    in0 holds a word
//   in0_ready    unit accepts in0 this cycle
//   out0         current byte (0 when no byte is held)
//   out0_valid   out0 holds a byte
//   out0_ready   consumer takes out0 this cycle
//   busy         word held, bytes pending
//   byte_cnt     bytes emitted since last run, saturating
// -----------------------------------------------------------------------------
module endian_byte_unpacker #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              enabled,
  input  logic [DATA_W-1:0] in0,
  input  logic              in0_valid,
  output logic              in0_ready,
  output logic [7:0]        out0,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  byte_cnt
);

  localparam int unsigned BYTES    = DATA_W / 8;
  localparam int unsigned IDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned LAST_IDX = BYTES - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EMPTY = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   word_q,  word_d;
  logic                order_q, order_d;
  logic [IDX_W-1:0]    idx_q,   idx_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;

  logic                hold_c;
  logic                last_c;
  logic                xfer_c;
  logic                accept_c;
  logic                cnt_sat_c;
  logic [IDX_W-1:0]    sel_c;
  logic [7:0]          byte_c;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      order_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      order_q <= order_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake qualifiers
  always_comb begin
    hold_c    = (state_q == ST_HOLD);
    last_c    = (idx_q == IDX_W'(LAST_IDX));
    xfer_c    = hold_c & out0_ready;
    cnt_sat_c = (cnt_q == {CNT_W{1'b1}});
    // A new word may enter only when the slot is empty or the last byte is
    // leaving this very edge; a run pulse blocks acceptance.
    in0_ready = ~run & ((state_q == ST_EMPTY) | (xfer_c & last_c));
    accept_c  = in0_valid & in0_ready;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    order_d = order_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;

    if (run) begin
      state_d = ST_EMPTY;
      word_d  = '0;
      order_d = 1'b0;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      if (xfer_c) begin
        if (!cnt_sat_c) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (last_c) begin
          state_d = ST_EMPTY;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      // Accept overrides the drop to EMPTY when it coincides with the last byte.
      if (accept_c) begin
        state_d = ST_HOLD;
        word_d  = in0;
        order_d = enabled;
        idx_d   = '0;
      end
    end
  end

  // Byte selection: MSB-first walks the word from the top byte down.
  always_comb begin
    sel_c  = order_q ? (IDX_W'(LAST_IDX) - idx_q) : idx_q;
    byte_c = 8'h00;
    for (int unsigned b = 0; b < BYTES; b++) begin
      if (sel_c == IDX_W'(b)) begin
        byte_c = word_q[b*8 +: 8];
      end
    end
  end

  // Output decode from held state
  always_comb begin
    out0_valid = hold_c;
    busy       = hold_c;
    out0       = hold_c ? byte_c : 8'h00;
    byte_cnt   = cnt_q;
  end

endmodule
